tx_sched_rr: RTL and testbench
==============================

# tx_sched_rr

Work-conserving round-robin scheduler with per-requester burst quotas that decides which sub-AFU TX FIFO is dequeued each cycle. It replaces fixed time-slot polling in the TX multiplexing path: empty requesters are skipped at no cost, and grants stop cleanly under host almost-full. One instance serves one CCI-P TX channel (c0, c1 or c2). The grant drives the FIFO dequeue enables and the output select of that channel's mux.

## Interface
- N_REQ, 16 — number of requesters (sub-AFUs); ≥2.
- QUOTA_W, 4 — width of a per-requester burst quota.
- DEFAULT_QUOTA, 1 — quota loaded into every requester at reset.
- STARVE_LIMIT, 1024 — wait-cycle threshold for the starvation monitor.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req  in  N_REQ  bit i = FIFO i not empty.
- req_multi  in  N_REQ  bit i = FIFO i holds ≥2 entries.
- host_almFull  in  1  downstream channel almost full; blocks new grants.
- quota_wr_en  in  1  quota write strobe.
- quota_wr_idx  in  $clog2(N_REQ)  requester whose quota is written.
- quota_wr_data  in  QUOTA_W  new quota; 0 is treated as 1.
- grant_valid  out  1  a dequeue is granted this cycle.
- grant_idx  out  $clog2(N_REQ)  granted requester.
- grant_onehot  out  N_REQ  one-hot dequeue enables; all zero when grant_valid=0.
- starve_flag  out  N_REQ  requester i waiting ≥ STARVE_LIMIT cycles.

## Operation
- State:
  - owner: last granted index. Reset value N_REQ-1, so the first search starts at 0.
  - burst_cnt: QUOTA_W bits, reset 0.
  - quota[N_REQ]: reset DEFAULT_QUOTA.
  - last_grant: one-hot copy of the previous cycle's grant.
- Effective request: eff_req[i] = req[i] & ~(last_grant[i] & ~req_multi[i]). This prevents a second dequeue of a one-entry FIFO whose notEmpty flag has not yet updated.
- Decision each cycle:
  - **HOLD:** if host_almFull=1 or eff_req=0, no grant next cycle. owner and burst_cnt are unchanged.
  - **CONTINUE:** else if eff_req[owner] and burst_cnt < max(quota[owner],1), grant owner again and increment burst_cnt.
  - **ROTATE:** else grant the first i with eff_req[i], searching owner+1, owner+2, … and wrapping modulo N_REQ. The search ends at owner itself, so the owner may win only if it is the sole requester. Set owner=i and burst_cnt=1.
- The states are implicit in the HOLD/CONTINUE/ROTATE decision; no other FSM state exists.
- Quota writes:
  - A write updates quota[quota_wr_idx] at the clock edge.
  - A decision made in the same cycle uses the old value.
  - Lowering the owner's quota below burst_cnt ends the burst at the next decision.
- Wrap-around: the index after N_REQ-1 is 0. burst_cnt never exceeds 2^QUOTA_W-1.
- Exactly one bit of grant_onehot is set when grant_valid=1.

## Timing
- Grant is registered: req/req_multi/host_almFull sampled at edge t produce grant outputs valid after edge t+1 (1-cycle latency).
- host_almFull asserted in cycle t means no grant in cycle t+1. Grants already issued are not retracted.
- Reset (any cycle, including mid-burst):
  - grant_valid=0, grant_idx=0, grant_onehot=0, starve_flag=0.
  - All state returns to its reset values.
  - The first grant can appear 1 cycle after reset deasserts.
- Peak throughput: one grant per cycle. A single requester holding req_multi=1 can be granted every cycle, since it is the sole requester.

## Configuration
- TX_SCHED_STARVE_MON_EN defined:
  - Each requester has a 16-bit saturating wait counter.
  - The counter increments every cycle req[i]=1 and requester i is not granted, and clears on grant or when req[i]=0.
  - starve_flag[i] = (counter ≥ STARVE_LIMIT), registered.
- Not defined: no counters are built and starve_flag is tied to 0.

## Test plan
- Reset, then req=16'h0001, req_multi=0 held → grants to idx 0 in alternating cycles only (last_grant mask); grant_onehot=16'h0001 when valid.
- req=16'hFFFF, req_multi=16'hFFFF, all quotas 1 → grant_idx sequence 0,1,2,…,15,0 with grant_valid=1 every cycle.
- quota[3]=4, req=16'h0018, req_multi=16'h0018 → pattern 3,3,3,3,4,3,3,3,3,4…
- Same setup as the previous scenario; assert host_almFull for 5 cycles mid-burst of idx 3 → 5 cycles of grant_valid=0, then idx 3 resumes with its remaining burst count.
- req=16'h8001 full-rate, reset asserted mid-stream → outputs zero the next cycle; the first grant after release is idx 0.
- With TX_SCHED_STARVE_MON_EN and STARVE_LIMIT=8: quota[0]=15, req=16'h0003 (bit 1 has req_multi=0) → starve_flag[1] rises after 8 wait cycles and clears the cycle after idx 1 is granted. Without the macro, starve_flag stays 0.

Source files
------------

// File: rtl/tx_sched_rr.sv
// Work-conserving round-robin TX dequeue scheduler with per-requester burst quotas.
// Optional starvation monitor is built when TX_SCHED_STARVE_MON_EN is defined.
module tx_sched_rr #(
  parameter int N_REQ         = 16,
  parameter int QUOTA_W       = 4,
  parameter int DEFAULT_QUOTA = 1,
  parameter int STARVE_LIMIT  = 1024,
  localparam int IDX_W        = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_multi,
  input  logic               host_almFull,
  input  logic               quota_wr_en,
  input  logic [IDX_W-1:0]   quota_wr_idx,
  input  logic [QUOTA_W-1:0] quota_wr_data,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [N_REQ-1:0]   grant_onehot,
  output logic [N_REQ-1:0]   starve_flag
);

  typedef enum logic [1:0] {
    DEC_HOLD,
    DEC_CONT,
    DEC_ROT
  } dec_t;

  localparam logic [QUOTA_W-1:0] DEF_Q   = QUOTA_W'(DEFAULT_QUOTA);
  localparam logic [N_REQ-1:0]   ONE_BIT = N_REQ'(1);

  if (N_REQ < 2 || STARVE_LIMIT < 1) begin : g_bad_params
  end

  logic [IDX_W-1:0]   r_owner;
  logic [QUOTA_W-1:0] r_burst_cnt;
  logic [QUOTA_W-1:0] r_quota [N_REQ];
  logic               r_grant_valid;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [N_REQ-1:0]   r_grant_onehot;

  logic [N_REQ-1:0]   w_eff_req;
  logic [QUOTA_W-1:0] w_quota_eff;
  logic               w_rot_found;
  logic [IDX_W-1:0]   w_rot_idx;
  dec_t               w_dec;

  // A FIFO dequeued this cycle with a single entry still shows notEmpty; mask it.
  assign w_eff_req   = req & ~(r_grant_onehot & ~req_multi);
  assign w_quota_eff = (r_quota[r_owner] == '0) ? QUOTA_W'(1) : r_quota[r_owner];

  // NOTE: every always_comb output gets a default before the loop/if so no latch is inferred.
  always_comb begin
    w_rot_found = 1'b0;
    w_rot_idx   = r_owner;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_rot_found && w_eff_req[(int'(r_owner) + k) % N_REQ]) begin
        w_rot_found = 1'b1;
        w_rot_idx   = IDX_W'((int'(r_owner) + k) % N_REQ);
      end
    end
  end

  // burst_cnt==0 means no burst is open (only after reset), so the first grant always rotates from 0.
  always_comb begin
    w_dec = DEC_HOLD;
    if (!host_almFull && (|w_eff_req)) begin
      if ((r_burst_cnt != '0) && w_eff_req[r_owner] && (r_burst_cnt < w_quota_eff))
        w_dec = DEC_CONT;
      else
        w_dec = DEC_ROT;
    end
  end

  // NOTE: the quota table is reset because reset must reload DEFAULT_QUOTA, unlike a data RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner        <= IDX_W'(N_REQ - 1);
      r_burst_cnt    <= '0;
      r_grant_valid  <= 1'b0;
      r_grant_idx    <= '0;
      r_grant_onehot <= '0;
      for (int i = 0; i < N_REQ; i++) r_quota[i] <= DEF_Q;
    end else begin
      case (w_dec)
        DEC_CONT: begin
          r_grant_valid  <= 1'b1;
          r_grant_idx    <= r_owner;
          r_grant_onehot <= ONE_BIT << r_owner;
          r_burst_cnt    <= r_burst_cnt + QUOTA_W'(1);
        end
        DEC_ROT: begin
          r_grant_valid  <= 1'b1;
          r_grant_idx    <= w_rot_idx;
          r_grant_onehot <= ONE_BIT << w_rot_idx;
          r_owner        <= w_rot_idx;
          r_burst_cnt    <= QUOTA_W'(1);
        end
        default: begin
          r_grant_valid  <= 1'b0;
          r_grant_idx    <= '0;
          r_grant_onehot <= '0;
        end
      endcase
      if (quota_wr_en) r_quota[quota_wr_idx] <= quota_wr_data;
    end
  end

  assign grant_valid  = r_grant_valid;
  assign grant_idx    = r_grant_idx;
  assign grant_onehot = r_grant_onehot;

`ifdef TX_SCHED_STARVE_MON_EN
  logic [15:0]      r_wait [N_REQ];
  logic [15:0]      w_wait_next [N_REQ];
  logic [N_REQ-1:0] r_starve;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_wait_next[i] = '0;
      if (req[i] && !r_grant_onehot[i])
        w_wait_next[i] = (r_wait[i] == 16'hFFFF) ? r_wait[i] : r_wait[i] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
      for (int i = 0; i < N_REQ; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        r_wait[i]   <= w_wait_next[i];
        r_starve[i] <= ({16'd0, w_wait_next[i]} >= 32'(STARVE_LIMIT));
      end
    end
  end

  assign starve_flag = r_starve;
`else
  assign starve_flag = '0;
`endif

endmodule

// File: tb/tb_tx_sched_rr.sv
// Self-checking bench for tx_sched_rr: per-cycle scheduler model plus directed literal checks.
module tb_tx_sched_rr;
  localparam int N     = 16;
  localparam int QW    = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_multi = '0;
  logic          host_almFull = 1'b0;
  logic          quota_wr_en = 1'b0;
  logic [3:0]    quota_wr_idx = '0;
  logic [QW-1:0] quota_wr_data = '0;
  logic          grant_valid;
  logic [3:0]    grant_idx;
  logic [N-1:0]  grant_onehot;
  logic [N-1:0]  starve_flag;

  tx_sched_rr #(
    .N_REQ(N), .QUOTA_W(QW), .DEFAULT_QUOTA(1), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_multi(req_multi),
    .host_almFull(host_almFull), .quota_wr_en(quota_wr_en),
    .quota_wr_idx(quota_wr_idx), .quota_wr_data(quota_wr_data),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .grant_onehot(grant_onehot), .starve_flag(starve_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner, m_burst;
  int m_quota [N];
  int m_wait [N];
  bit m_valid;
  int m_idx;
  bit m_known = 1'b0;

  task automatic model_step();
    bit elig [N];
    bit any;
    int q;
    bit nv;
    int ni;
    if (reset) begin
      m_owner = N - 1; m_burst = 0;
      for (int i = 0; i < N; i++) begin m_quota[i] = 1; m_wait[i] = 0; end
      m_valid = 1'b0; m_idx = 0; m_known = 1'b1;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (req[i] && !(m_valid && m_idx == i))
        m_wait[i] = (m_wait[i] >= 65535) ? 65535 : m_wait[i] + 1;
      else
        m_wait[i] = 0;
    end
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      elig[i] = req[i] && !(m_valid && m_idx == i && !req_multi[i]);
      any = any | elig[i];
    end
    q  = (m_quota[m_owner] == 0) ? 1 : m_quota[m_owner];
    nv = 1'b0; ni = 0;
    if (!host_almFull && any) begin
      nv = 1'b1;
      if (m_burst > 0 && elig[m_owner] && m_burst < q) begin
        ni = m_owner; m_burst++;
      end else begin
        for (int k = N; k >= 1; k--)
          if (elig[(m_owner + k) % N]) ni = (m_owner + k) % N;
        m_owner = ni; m_burst = 1;
      end
    end
    m_valid = nv; m_idx = ni;
    if (quota_wr_en) m_quota[quota_wr_idx] = int'(quota_wr_data);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (m_known) begin
        logic [N-1:0] exp_oh;
        logic [N-1:0] exp_sf;
        exp_oh = '0;
        if (m_valid) exp_oh[m_idx] = 1'b1;
        exp_sf = '0;
`ifdef TX_SCHED_STARVE_MON_EN
        for (int i = 0; i < N; i++) exp_sf[i] = (m_wait[i] >= LIMIT);
`endif
        check("model_valid", 64'(grant_valid), 64'(m_valid));
        check("model_onehot", 64'(grant_onehot), 64'(exp_oh));
        check("model_starve", 64'(starve_flag), 64'(exp_sf));
        if (m_valid) check("model_idx", 64'(grant_idx), 64'(m_idx));
      end
      model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_multi = '0; host_almFull = 1'b0; quota_wr_en = 1'b0;
    tick(); tick();
    check("reset_valid", 64'(grant_valid), 64'd0);
    check("reset_idx", 64'(grant_idx), 64'd0);
    check("reset_onehot", 64'(grant_onehot), 64'd0);
    check("reset_starve", 64'(starve_flag), 64'd0);
    reset = 1'b0;
  endtask

  task automatic wr_quota(input int idx, input int data);
    quota_wr_en = 1'b1; quota_wr_idx = 4'(idx); quota_wr_data = QW'(data);
    tick();
    quota_wr_en = 1'b0;
  endtask

  initial begin
    int seq3 [10] = '{3, 3, 3, 3, 4, 3, 3, 3, 3, 4};
    int v4 [11]   = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    int i4 [11]   = '{3, 3, 0, 0, 0, 0, 0, 3, 3, 4, 3};
    int i6 [4]    = '{3, 4, 3, 4};

    // Single one-entry requester: granted every other cycle.
    do_reset();
    req = 16'h0001; req_multi = 16'h0000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("single_valid", 64'(grant_valid), 64'(k % 2));
      if (k % 2 == 1) check("single_onehot", 64'(grant_onehot), 64'h0001);
    end

    // All requesters, quota 1: full-rate rotation 0..15,0.
    do_reset();
    req = 16'hFFFF; req_multi = 16'hFFFF;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("rr_valid", 64'(grant_valid), 64'd1);
      check("rr_idx", 64'(grant_idx), 64'((k - 1) % 16));
    end

    // quota[3]=4 against idx 4.
    do_reset();
    wr_quota(3, 4);
    req = 16'h0018; req_multi = 16'h0018;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("quota_idx", 64'(grant_idx), 64'(seq3[k]));
    end

    // Host almost-full for 5 decisions in the middle of idx 3's burst.
    do_reset();
    wr_quota(3, 4);
    req = 16'h0018; req_multi = 16'h0018;
    for (int k = 0; k < 11; k++) begin
      tick();
      check("almfull_valid", 64'(grant_valid), 64'(v4[k]));
      if (v4[k] == 1) check("almfull_idx", 64'(grant_idx), 64'(i4[k]));
      if (k == 1) host_almFull = 1'b1;
      if (k == 6) host_almFull = 1'b0;
    end

    // Reset mid-stream.
    do_reset();
    req = 16'h8001; req_multi = 16'h8001;
    tick(); tick(); tick();
    check("stream_idx", 64'(grant_idx), 64'd0);
    reset = 1'b1;
    tick();
    check("midrst_valid", 64'(grant_valid), 64'd0);
    check("midrst_idx", 64'(grant_idx), 64'd0);
    check("midrst_onehot", 64'(grant_onehot), 64'd0);
    reset = 1'b0;
    tick();
    check("postrst_valid", 64'(grant_valid), 64'd1);
    check("postrst_idx", 64'(grant_idx), 64'd0);

    // Quota lowered to 0 mid-burst: same-cycle decision uses old value, then 0 acts as 1.
    do_reset();
    wr_quota(3, 4);
    req = 16'h0018; req_multi = 16'h0018;
    tick(); tick();
    quota_wr_en = 1'b1; quota_wr_idx = 4'd3; quota_wr_data = '0;
    tick();
    check("qlow_idx0", 64'(grant_idx), 64'(i6[0]));
    quota_wr_en = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("qlow_idx", 64'(grant_idx), 64'(i6[k]));
    end

    // Starvation: idx 0 holds a 15-grant burst while idx 1 waits.
    do_reset();
    wr_quota(0, 15);
    req = 16'h0003; req_multi = 16'h0001;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 16) check("starve_grant_idx", 64'(grant_idx), 64'd1);
`ifdef TX_SCHED_STARVE_MON_EN
      if (k == 7)  check("starve_before", 64'(starve_flag[1]), 64'd0);
      if (k == 8)  check("starve_rise", 64'(starve_flag[1]), 64'd1);
      if (k == 16) check("starve_hold", 64'(starve_flag[1]), 64'd1);
      if (k == 17) check("starve_clear", 64'(starve_flag[1]), 64'd0);
`else
      check("starve_off", 64'(starve_flag), 64'd0);
`endif
    end

    req = '0;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
